// File: rtl/seg7_display_driver.sv
// seg7_display_driver: latches a 32-bit value and shows it on an 8-digit,
// multiplexed, common-anode seven-segment display. The value is shown in hex,
// or in decimal after an iterative double-dabble conversion.
// Ports:
//   clk, rst        system clock; synchronous active-high reset
//   load            one-cycle capture strobe for value/dec_mode/blank_lz.
//                   It is honoured only while busy is low. A load that
//                   arrives while busy is high is dropped, not queued.
//   value           number to display
//   dec_mode        1 = decimal via BCD conversion, 0 = hexadecimal
//   blank_lz        1 = blank leading zero digits (digit 0 always shown)
//   seg_en          active-low one-hot digit enable, bit 0 = rightmost digit
//   seg_out         active-low segments {dp,g,f,e,d,c,b,a}; dp always off
//   busy            capture/conversion in progress
//   overflow        last committed decimal value exceeded 99,999,999
// Latency: hex commit 1 cycle after capture; decimal commit 33 cycles after
// capture (32 conversion steps plus the commit). seg_en/seg_out are
// registered, so they lag the scan index and display register by one cycle.
module seg7_display_driver #(
    parameter int SCAN_BITS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    input  logic        dec_mode,
    input  logic        blank_lz,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Conversion / capture state
    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [39:0]    bcd_q, bcd_d;
    logic [31:0]    bin_q, bin_d;
    logic [31:0]    val_q, val_d;
    logic           dec_q, dec_d;
    logic           blank_cap_q, blank_cap_d;

    // Committed display state. blank_lz is applied at commit together with
    // the digits, so a new request cannot change the look of the old number.
    logic [31:0]    disp_q, disp_d;
    logic           ovf_q, ovf_d;
    logic           blank_disp_q, blank_disp_d;

    // Scanning
    logic [SCAN_BITS-1:0] presc_q, presc_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     seg_en_q, seg_en_d;
    logic [7:0]     seg_out_q, seg_out_d;

    // Helpers
    logic [39:0]    bcd_adj;
    logic [7:0]     zero_from;
    logic [3:0]     cur_nib;

    // Glyphs for common-anode segments, {dp,g,f,e,d,c,b,a}, active-low.
    function automatic logic [7:0] glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'h88;
            4'hB:    g = 8'h83;
            4'hC:    g = 8'hC6;
            4'hD:    g = 8'hA1;
            4'hE:    g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Capture / conversion FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bcd_d        = bcd_q;
        bin_d        = bin_q;
        val_d        = val_q;
        dec_d        = dec_q;
        blank_cap_d  = blank_cap_q;
        disp_d       = disp_q;
        ovf_d        = ovf_q;
        blank_disp_d = blank_disp_q;
        bcd_adj      = bcd_q;

        // Double-dabble correction: any BCD nibble >= 5 gets +3 before the
        // shift, so that it carries correctly into the next decade.
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    val_d       = value;
                    dec_d       = dec_mode;
                    blank_cap_d = blank_lz;
                    if (dec_mode) begin
                        bcd_d   = 40'd0;
                        bin_d   = value;
                        cnt_d   = 5'd0;
                        state_d = CONV;
                    end else begin
                        state_d = COMMIT;
                    end
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (dec_q) begin
                    disp_d = bcd_q[31:0];
                    ovf_d  = |bcd_q[39:32];
                end else begin
                    disp_d = val_q;
                    ovf_d  = 1'b0;
                end
                blank_disp_d = blank_cap_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scan and segment decode
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (&presc_q) begin
            idx_d = idx_q + 3'd1;     // 3-bit index wraps 7 -> 0
        end

        // zero_from[i] = every nibble at index >= i is zero.
        zero_from    = 8'h00;
        zero_from[7] = (disp_q[31:28] == 4'h0);
        for (int i = 6; i >= 0; i--) begin
            zero_from[i] = (disp_q[4*i +: 4] == 4'h0) && zero_from[i+1];
        end

        cur_nib  = disp_q[{idx_q, 2'b00} +: 4];
        seg_en_d = ~(8'h01 << idx_q);

        if (ovf_q) begin
            seg_out_d = 8'hBF;        // '-' on every digit
        end else if (blank_disp_q && (idx_q != 3'd0) && zero_from[idx_q]) begin
            seg_out_d = 8'hFF;
        end else begin
            seg_out_d = glyph(cur_nib);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 5'd0;
            bcd_q        <= 40'd0;
            bin_q        <= 32'd0;
            val_q        <= 32'd0;
            dec_q        <= 1'b0;
            blank_cap_q  <= 1'b0;
            disp_q       <= 32'd0;
            ovf_q        <= 1'b0;
            blank_disp_q <= 1'b0;
            presc_q      <= '0;
            idx_q        <= 3'd0;
            seg_en_q     <= 8'hFF;
            seg_out_q    <= 8'hFF;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
            bin_q        <= bin_d;
            val_q        <= val_d;
            dec_q        <= dec_d;
            blank_cap_q  <= blank_cap_d;
            disp_q       <= disp_d;
            ovf_q        <= ovf_d;
            blank_disp_q <= blank_disp_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            seg_en_q     <= seg_en_d;
            seg_out_q    <= seg_out_d;
        end
    end

    assign seg_en   = seg_en_q;
    assign seg_out  = seg_out_q;
    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
module tb_seg7_display_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] value;
    logic        dec_mode;
    logic        blank_lz;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic        busy;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] dig [8];
    int         bad_en;

    always #5 clk = ~clk;

    seg7_display_driver #(.SCAN_BITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .dec_mode (dec_mode),
        .blank_lz (blank_lz),
        .seg_en   (seg_en),
        .seg_out  (seg_out),
        .busy     (busy),
        .overflow (overflow)
    );

    // Observe 40 cycles of scanning and record the last glyph seen per digit.
    task automatic capture();
        int hit;
        int cnt;
        bad_en = 0;
        for (int i = 0; i < 8; i++) dig[i] = 8'hxx;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            hit = -1;
            cnt = 0;
            for (int i = 0; i < 8; i++) begin
                if (seg_en[i] === 1'b0) begin
                    hit = i;
                    cnt++;
                end
            end
            if (cnt == 1 && seg_en[hit] === 1'b0) dig[hit] = seg_out;
            else bad_en++;
        end
    endtask

    // Issue one load and count negedges on which busy is high (bounded).
    task automatic do_load(input logic [31:0] v, input logic d, input logic b,
                           output int busy_cycles);
        @(negedge clk);
        load = 1'b1; value = v; dec_mode = d; blank_lz = b;
        @(negedge clk);
        load = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_en;
        rst = 1'b1; load = 1'b0; value = '0; dec_mode = 1'b0; blank_lz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (seg_en !== 8'hFF) begin n_fail++; $display("FAIL reset_seg_en: got %h expected ff", seg_en); end
        n_checks++; if (seg_out !== 8'hFF) begin n_fail++; $display("FAIL reset_seg_out: got %h expected ff", seg_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            exp_en = ~(8'h01 << (((n - 1) / 4) % 8));
            n_checks++; if (seg_en !== exp_en) begin n_fail++; $display("FAIL scan_seg_en edge %0d: got %h expected %h", n, seg_en, exp_en); end
            n_checks++; if (seg_out !== 8'hC0) begin n_fail++; $display("FAIL scan_seg_out edge %0d: got %h expected c0", n, seg_out); end
        end
    endtask

    task automatic test_hex();
        logic [7:0] exp [8];
        int bc;
        int hit;
        exp = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        do_load(32'h1234ABCD, 1'b0, 1'b0, bc);
        n_checks++; if (bc != 1) begin n_fail++; $display("FAIL hex_busy_cycles: got %0d expected 1", bc); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL hex_overflow: got %b expected 0", overflow); end
        // One more edge: the new digits must already be on seg_out.
        @(negedge clk);
        hit = -1;
        for (int i = 0; i < 8; i++) if (seg_en[i] === 1'b0) hit = i;
        n_checks++;
        if (hit < 0) begin n_fail++; $display("FAIL hex_latency: got seg_en %h expected one digit enabled", seg_en); end
        else if (seg_out !== exp[hit]) begin n_fail++; $display("FAIL hex_latency digit %0d: got %h expected %h", hit, seg_out, exp[hit]); end
        capture();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (dig[i] !== exp[i]) begin n_fail++; $display("FAIL hex_digit %0d: got %h expected %h", i, dig[i], exp[i]); end
        end
    endtask

    task automatic test_dec_blank();
        logic [7:0] exp [8];
        int bc;
        exp = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF};
        do_load(32'd12345, 1'b1, 1'b1, bc);
        n_checks++; if (bc != 33) begin n_fail++; $display("FAIL dec_busy_cycles: got %0d expected 33", bc); end
        capture();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (dig[i] !== exp[i]) begin n_fail++; $display("FAIL dec_digit %0d: got %h expected %h", i, dig[i], exp[i]); end
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL dec_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_overflow();
        int bc;
        do_load(32'd100000000, 1'b1, 1'b1, bc);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        capture();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (dig[i] !== 8'hBF) begin n_fail++; $display("FAIL ovf_digit %0d: got %h expected bf", i, dig[i]); end
        end
        do_load(32'd99999999, 1'b1, 1'b1, bc);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL max_flag: got %b expected 0", overflow); end
        capture();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (dig[i] !== 8'h90) begin n_fail++; $display("FAIL max_digit %0d: got %h expected 90", i, dig[i]); end
        end
    endtask

    task automatic test_load_while_busy();
        logic [7:0] exp [8];
        exp = '{8'hF8, 8'hF8, 8'hF8, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        @(negedge clk);
        load = 1'b1; value = 32'd777; dec_mode = 1'b1; blank_lz = 1'b0;
        @(negedge clk);
        // Pulse a hex load in mid-conversion and again in the COMMIT cycle.
        for (int j = 1; j <= 33; j++) begin
            load = (j == 5 || j == 33); value = 32'h5; dec_mode = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_commit: got %b expected 0", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_not_queued: got %b expected 0", busy); end
        capture();
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (dig[i] !== exp[i]) begin n_fail++; $display("FAIL ignored_load digit %0d: got %h expected %h", i, dig[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid_conv();
        int bc;
        do_load(32'd100000000, 1'b1, 1'b0, bc);
        @(negedge clk);
        load = 1'b1; value = 32'd12345; dec_mode = 1'b1; blank_lz = 1'b0;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
        n_checks++; if (seg_en !== 8'hFF) begin n_fail++; $display("FAIL midrst_seg_en: got %h expected ff", seg_en); end
        n_checks++; if (seg_out !== 8'hFF) begin n_fail++; $display("FAIL midrst_seg_out: got %h expected ff", seg_out); end
        rst = 1'b0;
        capture();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_conv_discarded: got busy %b expected 0", busy); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (dig[i] !== 8'hC0) begin n_fail++; $display("FAIL midrst_digit %0d: got %h expected c0", i, dig[i]); end
        end
    endtask

    task automatic test_zero_wrap();
        int bc;
        int wraps;
        int glitches;
        logic [7:0] prev;
        do_load(32'd0, 1'b1, 1'b1, bc);
        n_checks++; if (bc != 33) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 33", bc); end
        capture();
        n_checks++; if (bad_en != 0) begin n_fail++; $display("FAIL zero_seg_en_onehot: got %0d bad cycles expected 0", bad_en); end
        n_checks++; if (dig[0] !== 8'hC0) begin n_fail++; $display("FAIL zero_digit 0: got %h expected c0", dig[0]); end
        for (int i = 1; i < 8; i++) begin
            n_checks++; if (dig[i] !== 8'hFF) begin n_fail++; $display("FAIL zero_digit %0d: got %h expected ff", i, dig[i]); end
        end
        wraps = 0;
        glitches = 0;
        prev = seg_en;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (prev === 8'h7F) begin
                if (seg_en === 8'hFE) wraps++;
                else if (seg_en !== 8'h7F) glitches++;
            end
            prev = seg_en;
        end
        n_checks++; if (wraps < 1) begin n_fail++; $display("FAIL wrap_seen: got %0d wraps expected at least 1", wraps); end
        n_checks++; if (glitches != 0) begin n_fail++; $display("FAIL wrap_glitch: got %0d expected 0", glitches); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hex();
        test_dec_blank();
        test_overflow();
        test_load_while_busy();
        test_reset_mid_conv();
        test_zero_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
